// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment scan driver with frame-synchronous (tear-free) display updates.
// Optional macro SEG7_LZ_BLANK_EN blanks leading-zero digits above digit 0.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    upd_done
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]              cnt;
    logic [IW-1:0]              idx;
    logic [NUM_DIGITS-1:0][3:0] disp;
    logic [NUM_DIGITS-1:0][3:0] shadow;
    logic                       pending;
    logic                       cnt_wrap;
    logic                       idx_last;
    logic                       commit;
    logic [3:0]                 nib;
    logic [6:0]                 seg_next;
    logic [NUM_DIGITS-1:0]      an_next;

    assign cnt_wrap = (cnt == CW'(REFRESH_DIV - 1));
    assign idx_last = (idx == IW'(NUM_DIGITS - 1));
    // Display only changes on the last cycle of a frame, so a scan never mixes old and new digits.
    assign commit   = cnt_wrap && idx_last && pending;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

`ifdef SEG7_LZ_BLANK_EN
    // upper_zero[i]: digit i and every digit above it are zero.
    logic [NUM_DIGITS-1:0] upper_zero;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_uz
        assign upper_zero[i] = (disp[NUM_DIGITS-1:i] == '0);
    end
`endif

    always_comb begin
        nib      = disp[idx];
        seg_next = hex7(nib);
`ifdef SEG7_LZ_BLANK_EN
        if (idx != '0 && upper_zero[idx]) seg_next = 7'b1111111;
`endif
        an_next  = ~(NUM_DIGITS'(1) << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            idx      <= '0;
            disp     <= '0;
            shadow   <= '0;
            pending  <= 1'b0;
            seg      <= 7'b1111111;
            an       <= '1;
            upd_done <= 1'b0;
        end else begin
            cnt <= cnt_wrap ? '0 : cnt + 1'b1;
            if (cnt_wrap) idx <= idx_last ? '0 : idx + 1'b1;
            if (commit) begin
                disp    <= shadow;
                pending <= 1'b0;
            end
            // A coincident load overrides the pending clear and refills shadow after its old value committed.
            if (load) begin
                shadow  <= value;
                pending <= 1'b1;
            end
            upd_done <= commit;
            seg      <= seg_next;
            an       <= an_next;
        end
    end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed digits; legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles each digit is lit; legal range >= 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port load, input, 1 bit: request to capture value.
REQ-006 SHALL have port value, input, 4*NUM_DIGITS bits: hex nibbles, digit i = value[4i+3:4i], digit 0 least significant.
REQ-007 SHALL have port seg, output, 7 bits: active-low segments, seg[0]=a ... seg[6]=g.
REQ-008 SHALL have port an, output, NUM_DIGITS bits: active-low digit enables, one-hot-low when lit.
REQ-009 SHALL have port upd_done, output, 1 bit: one-cycle pulse when a pending value is committed to the display.

Function
REQ-010 SHALL keep a dwell counter 0..REFRESH_DIV-1, incrementing every cycle and wrapping to 0 at REFRESH_DIV-1.
REQ-011 SHALL keep a digit index 0..NUM_DIGITS-1, advancing by 1 on each counter wrap and wrapping NUM_DIGITS-1 -> 0.
REQ-012 SHALL define the frame boundary as the cycle where counter = REFRESH_DIV-1 and index = NUM_DIGITS-1.
REQ-013 SHALL on load=1 write value into a shadow register and set pending=1; a later load before commit overwrites it (latest wins).
REQ-014 SHALL at a frame boundary with pending=1 copy shadow to the display register, clear pending and pulse upd_done high for exactly that next cycle.
REQ-015 SHALL, when load and a committing frame boundary coincide, commit the pre-load shadow contents, write the new value to shadow and leave pending=1.
REQ-016 SHALL never change the displayed digits mid-frame (tear-free).
REQ-017 SHALL register seg and an: outputs reflect index and display register with 1-cycle latency.
REQ-018 SHALL drive an[index]=0 and all other an bits 1.
REQ-019 SHALL decode nibbles 0-F as full hex: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (seg[6:0]).
REQ-020 SHALL with NUM_DIGITS=1 keep an=0 permanently, with every counter wrap a frame boundary.

Reset
REQ-021 SHALL, while rst_n=0, force seg=7'b1111111, an=all ones, upd_done=0, counter=0, index=0, display=0, shadow=0, pending=0.
REQ-022 SHALL abandon any pending load on reset assertion mid-operation; no upd_done follows.
REQ-023 SHALL present digit 0 on an/seg on the first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL support macro SEG7_LZ_BLANK_EN; when defined, digit i (i>0) is blanked (seg=1111111, an still asserted) if it and all higher digits of the display register are 0.
REQ-025 SHALL, without SEG7_LZ_BLANK_EN, display every digit including leading zeros; digit 0 is never blanked in either build.

Verification
REQ-026 Reset: rst_n=0 mid-frame -> seg=1111111, an=1111, upd_done=0 immediately (asynchronously), digit 0 shown one edge after release.
REQ-027 Scan (NUM_DIGITS=4, REFRESH_DIV=4): free-run -> an sequence 1110,1101,1011,0111 each held 4 cycles, repeating every 16.
REQ-028 Commit: load value=16'h12AF mid-frame -> display unchanged until frame boundary, then upd_done one pulse, digits show F,A,2,1 patterns.
REQ-029 Coincident load: load 16'h0001 then load 16'h0002 on boundary cycle -> 0001 committed with upd_done, 0002 committed at next boundary with second pulse.
REQ-030 Blanking: value 16'h0005 -> with SEG7_LZ_BLANK_EN digits 1-3 seg=1111111, digit 0 = 0010010; without it digits 1-3 = 1000000.
